register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 8 +
 rtl/register_file.sv | 51 +++++
 tb/tb_register_file.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing constants for the register file.
// The zero register is hardwired to read 0.
package register_file_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/register_file.sv
// Register file with two combinational read ports and one write port.
// Each read port has a write-through bypass, and index 0 is hardwired to zero.
module register_file #(
    parameter int DATA_W = register_file_pkg::DATA_W,
    parameter int ADDR_W = register_file_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);
    import register_file_pkg::*;

    localparam int                NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NumRegs];
    logic              wrActive;

    // Gating on RegWrite first keeps X on the write index/data away from storage.
    assign wrActive = RegWrite && !Reset && (WriteRegister != ZeroIdx);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
        end else if (wrActive) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (Reset || ReadRegister1 == ZeroIdx)
            ReadData1 = '0;
        else if (wrActive && WriteRegister == ReadRegister1)
            ReadData1 = WriteData;
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (Reset || ReadRegister2 == ZeroIdx)
            ReadData2 = '0;
        else if (wrActive && WriteRegister == ReadRegister2)
            ReadData2 = WriteData;
    end
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: the stimulus pushes the expected read data, and a monitor compares it on the falling edge.
// The reference is a plain array with the architectural read rules.
module tb_register_file;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData1, ReadData2;

    typedef struct {
        logic [4:0]  a1, a2;
        logic [31:0] e1, e2;
    } exp_t;

    exp_t        expQ [$];
    exp_t        monEnt;
    logic [31:0] model [32];
    int          checks = 0;
    int          failures = 0;

    register_file dut (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .RegWrite(RegWrite),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] expRead(input logic [4:0] idx, input logic rst,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        if (rst || idx == 0) return 32'd0;
        if (we && wa == idx) return wd;
        return model[idx];
    endfunction

    // rstMode: 0 none, 1 held through the cycle, 2 short pulse between edges
    task automatic step(input int rstMode, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        if (rstMode == 2) begin
            Reset = 1'b1;
            #1;
            Reset = 1'b0;
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            #1;
        end else begin
            Reset = (rstMode == 1);
            if (rstMode == 1) for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end
        RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadRegister1 = r1; ReadRegister2 = r2;
        e.a1 = r1; e.a2 = r2;
        e.e1 = expRead(r1, rstMode == 1, we, wa, wd);
        e.e2 = expRead(r2, rstMode == 1, we, wa, wd);
        expQ.push_back(e);
        @(posedge Clk);
        if (rstMode != 1 && we && wa != 0) model[wa] = wd;
        #1;
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    always @(negedge Clk) begin
        if (expQ.size() > 0) begin
            monEnt = expQ.pop_front();
            checks += 2;
            if (ReadData1 !== monEnt.e1) begin
                failures++;
                $display("FAIL rd1 idx=%0d got=%h exp=%h t=%0t", monEnt.a1, ReadData1, monEnt.e1, $time);
            end
            if (ReadData2 !== monEnt.e2) begin
                failures++;
                $display("FAIL rd2 idx=%0d got=%h exp=%h t=%0t", monEnt.a2, ReadData2, monEnt.e2, $time);
            end
        end
    end

    initial begin
        Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(posedge Clk); #1;

        // reset state; write attempt while reset is held must be blocked
        step(1, 1'b1, 5'd20, 32'h1234_5678, 5'd20, 5'd24);
        rd(5'd20, 5'd24);

        step(0, 1'b1, 5'd1, 32'd1, 5'd0, 5'd0);
        step(0, 1'b1, 5'd2, 32'd2, 5'd0, 5'd0);
        step(0, 1'b1, 5'd3, 32'd3, 5'd0, 5'd0);
        step(0, 1'b1, 5'd31, 32'd1056, 5'd0, 5'd0);
        rd(5'd1, 5'd2);
        rd(5'd3, 5'd31);

        step(0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        rd(5'd0, 5'd0);

        step(0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd3);
        rd(5'd8, 5'd8);

        step(0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd1);
        step(0, 1'b0, 5'd9, 32'd5, 5'd9, 5'd9);
        rd(5'd9, 5'd31);

        // X on the write index and data with the write disabled
        step(0, 1'b0, 'x, 'x, 5'd2, 5'd31);
        rd(5'd1, 5'd9);

        for (int i = 8; i <= 25; i++) step(0, 1'b1, 5'(i), 32'(i * 3), 5'(i), 5'd31);
        for (int i = 8; i <= 25; i += 2) rd(5'(i), 5'(i + 1));
        step(2, 1'b0, 5'd0, 32'd0, 5'd8, 5'd25);
        for (int i = 8; i <= 25; i += 2) rd(5'(i), 5'(i + 1));
        step(0, 1'b1, 5'd10, 32'd7, 5'd11, 5'd12);
        rd(5'd10, 5'd10);

        for (int n = 0; n < 300; n++) begin
            logic [4:0]  wa, r1, r2;
            logic        we;
            logic [31:0] wd;
            int          rm;
            wa = 5'($urandom_range(0, 31));
            we = ($urandom_range(0, 3) != 0);
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rm = ($urandom_range(0, 60) == 0) ? int'($urandom_range(1, 2)) : 0;
            step(rm, we, wa, wd, r1, r2);
        end

        @(negedge Clk); #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
